// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART fifo write-side blocks: default byte width,
// arbiter state encodings and an index-width helper.
package uart_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Index width for n entries; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request after 'last',
// wrapping modulo NUM_REQ.
module rr_pick
  import uart_fifo_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest index after 'last' wins.
  always_comb begin
    found  = |req;
    winner = '0;
    idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last) + off) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one fifo write port among
// NUM_REQ byte producers; a grant lasts until the owner's last byte or MAX_BURST beats.
module fifo_wr_arbiter
  import uart_fifo_pkg::*;
#(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  MAX_BURST  = 16,
  localparam int GID_W      = idxWidth(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

  logic [0:0]            state_q, state_d;
  logic [GID_W-1:0]      grantId_q, grantId_d;
  logic [GID_W-1:0]      lastGnt_q, lastGnt_d;
  logic [CNT_W-1:0]      beatCnt_q, beatCnt_d;

  logic                  pickFound;
  logic [GID_W-1:0]      pickIdx;
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  logic                  ownerValid;
  logic                  ownerLast;
  logic                  releaseGrant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_pick (
    .req    (req_valid),
    .last   (lastGnt_q),
    .found  (pickFound),
    .winner (pickIdx)
  );

  assign ownerValid   = req_valid[grantId_q];
  assign ownerLast    = req_last[grantId_q];
  assign busy         = (state_q == ST_GRANT);
  assign grant_id     = grantId_q;
  assign fifo_wr_en   = busy & ownerValid & ~fifo_full;
  assign fifo_wdata   = fifo_wr_en ? lane[grantId_q] : '0;
  assign releaseGrant = fifo_wr_en & (ownerLast | (beatCnt_q == BURST_END));

  // Only the owner sees ready, and only while the fifo has room.
  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grantId_q] = ~fifo_full;
    end
  end

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    lastGnt_d = lastGnt_q;
    beatCnt_d = beatCnt_q;
    if (state_q == ST_IDLE) begin
      if (pickFound) begin
        grantId_d = pickIdx;
        state_d   = ST_GRANT;
      end
    end else if (fifo_wr_en) begin
      if (releaseGrant) begin
        state_d   = ST_IDLE;
        beatCnt_d = '0;
        lastGnt_d = grantId_q;
      end else begin
        beatCnt_d = beatCnt_q + CNT_W'(1);
      end
    end
  end

  // lastGnt resets to the top index so requester 0 wins the first grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grantId_q <= '0;
      lastGnt_q <= GID_W'(NUM_REQ - 1);
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      lastGnt_q <= lastGnt_d;
      beatCnt_q <= beatCnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter (NUM_REQ=2, MAX_BURST=4)
// against a depth-8 fifo model with a per-requester order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic        fifo_full, fifo_wr_en, busy;
  logic [7:0]  fifo_wdata;
  logic [0:0]  grant_id;

  logic        forceFull = 1'b0;
  logic        popEn = 1'b1;
  logic        sbEn = 1'b0;
  int          fifoCount = 0;
  logic [7:0]  fifoMem [$];

  int checks = 0;
  int errors = 0;
  int wrPulses = 0, overflowCnt = 0, fullCycles = 0;
  int orderErrs = 0, interleaveErrs = 0, sbWrites = 0, sbAccepts = 0;
  int curOwner = -1;
  int pulseMark;
  logic [6:0] expSeq [2];
  logic [6:0] prodSeq [2];
  int         prodRemain [2];

  always #5 clk = ~clk;

  assign fifo_full = forceFull | (fifoCount >= DEPTH);

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Fifo model, overflow watch and the random-phase scoreboard/producers.
  always @(posedge clk) begin
    int r;
    if (fifo_wr_en) begin
      wrPulses++;
      if (fifo_full) overflowCnt++;
      fifoMem.push_back(fifo_wdata);
    end
    if (fifo_full) fullCycles++;
    if (sbEn) begin
      if (fifo_wr_en) begin
        r = int'(fifo_wdata[7]);
        sbWrites++;
        if (fifo_wdata[6:0] != expSeq[r]) orderErrs++;
        expSeq[r] = expSeq[r] + 7'd1;
        if (curOwner >= 0 && curOwner != r) interleaveErrs++;
        curOwner = req_last[r] ? -1 : r;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbAccepts++;
          prodSeq[i] = prodSeq[i] + 7'd1;
          prodRemain[i]--;
          if (prodRemain[i] == 0) prodRemain[i] = $urandom_range(1, 4);
        end
      end
    end
    if (popEn && fifoMem.size() > 0) void'(fifoMem.pop_front());
    fifoCount = fifoMem.size();
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic expBusy, input logic expGid,
                            input logic expWr, input logic [7:0] expData, input logic [1:0] expReady);
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, ".grant_id"}, 32'(grant_id), 32'(expGid));
    checkOutput({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(expWr));
    checkOutput({tag, ".wdata"}, 32'(fifo_wdata), 32'(expData));
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'(expReady));
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] l,
                               input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_last  = l;
    req_data  = {d1, d0};
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    checkState("reset", 0, 0, 0, 8'h00, 2'b00);

    $display("[TB] simultaneous request, requester 0 wins first");
    @(negedge clk); applyStimulus(2'b11, 2'b00, 8'h41, 8'hB1);
    checkState("t1.idle", 0, 0, 0, 8'h00, 2'b00);
    @(negedge clk); applyStimulus(2'b11, 2'b00, 8'h41, 8'hB1);
    checkState("t1.b0", 1, 0, 1, 8'h41, 2'b01);
    @(negedge clk); applyStimulus(2'b11, 2'b01, 8'h42, 8'hB1);
    checkState("t1.b1", 1, 0, 1, 8'h42, 2'b01);
    @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'h10);
    checkState("t1.bubble", 0, 0, 0, 8'h00, 2'b00);
    pulseMark = wrPulses;

    $display("[TB] requester 1 streams without last");
    for (int k = 0; k < MAX_BURST; k++) begin
      @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'(8'h10 + k));
      checkState("t2.beat", 1, 1, 1, 8'(8'h10 + k), 2'b10);
    end
    @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'h14);
    checkState("t2.bubble", 0, 1, 0, 8'h00, 2'b00);
    checkOutput("t2.pulses", 32'(wrPulses - pulseMark), 32'd4);
    @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'h14);
    checkState("t2.regrant", 1, 1, 1, 8'h14, 2'b10);
    @(negedge clk); applyStimulus(2'b10, 2'b10, 8'h00, 8'h15);
    checkState("t2.last", 1, 1, 1, 8'h15, 2'b10);

    $display("[TB] fifo full stall mid-packet");
    @(negedge clk); applyStimulus(2'b01, 2'b00, 8'h20, 8'h00);
    checkState("t3.idle", 0, 1, 0, 8'h00, 2'b00);
    @(negedge clk); applyStimulus(2'b01, 2'b00, 8'h20, 8'h00);
    checkState("t3.b0", 1, 0, 1, 8'h20, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); forceFull = 1'b1; applyStimulus(2'b01, 2'b01, 8'h21, 8'h00);
      checkState("t3.full", 1, 0, 0, 8'h00, 2'b00);
    end
    for (int k = 1; k < MAX_BURST; k++) begin
      @(negedge clk); forceFull = 1'b0; applyStimulus(2'b01, 2'b00, 8'(8'h20 + k), 8'h00);
      checkState("t3.resume", 1, 0, 1, 8'(8'h20 + k), 2'b01);
    end
    @(negedge clk); applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    checkState("t3.release", 0, 0, 0, 8'h00, 2'b00);

    $display("[TB] owner pauses while other requester waits");
    @(negedge clk); applyStimulus(2'b01, 2'b00, 8'h30, 8'h00);
    checkState("t4.idle", 0, 0, 0, 8'h00, 2'b00);
    @(negedge clk); applyStimulus(2'b01, 2'b00, 8'h30, 8'h00);
    checkState("t4.b0", 1, 0, 1, 8'h30, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h31, 8'hB0);
      checkState("t4.hold", 1, 0, 0, 8'h00, 2'b01);
    end
    @(negedge clk); applyStimulus(2'b11, 2'b01, 8'h31, 8'hB0);
    checkState("t4.resume", 1, 0, 1, 8'h31, 2'b01);
    @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'hB0);
    checkState("t4.bubble", 0, 0, 0, 8'h00, 2'b00);
    @(negedge clk); applyStimulus(2'b10, 2'b00, 8'h00, 8'hB0);
    checkState("t4.g1", 1, 1, 1, 8'hB0, 2'b10);

    $display("[TB] reset during grant");
    #2 reset = 1'b1;
    #1 checkState("t5.rst", 0, 0, 0, 8'h00, 2'b00);
    @(negedge clk); reset = 1'b0; applyStimulus(2'b11, 2'b00, 8'h41, 8'hB1);
    checkState("t5.idle", 0, 0, 0, 8'h00, 2'b00);
    @(negedge clk); applyStimulus(2'b11, 2'b00, 8'h41, 8'hB1);
    checkState("t5.g0", 1, 0, 1, 8'h41, 2'b01);

    $display("[TB] random traffic against fifo model");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < NUM_REQ; i++) begin
      expSeq[i]     = '0;
      prodSeq[i]    = '0;
      prodRemain[i] = $urandom_range(1, 4);
    end
    @(negedge clk);
    reset = 1'b0;
    sbEn  = 1'b1;
    fullCycles = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i]         = ($urandom_range(0, 9) < 8);
        req_data[i*DW +: DW] = {1'(i), prodSeq[i]};
        req_last[i]          = (prodRemain[i] == 1);
      end
      popEn = ($urandom_range(0, 9) < 4);
      @(negedge clk);
    end
    sbEn = 1'b0;
    req_valid = '0;
    popEn = 1'b1;
    checkOutput("t6.order", 32'(orderErrs), 32'd0);
    checkOutput("t6.interleave", 32'(interleaveErrs), 32'd0);
    checkOutput("t6.writesEqAccepts", 32'(sbWrites), 32'(sbAccepts));
    checkOutput("t6.progress", 32'(sbWrites > 60), 32'd1);
    checkOutput("t6.fullSeen", 32'(fullCycles > 0), 32'd1);
    checkOutput("noWriteWhileFull", 32'(overflowCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
